fpu_issue_ctrl: RTL

- Sequencer directly upstream of the FPU datapath.
- Accepts one operation request (A, B, opcode, tag) over a valid/ready handshake and holds operands and opcode stable on the FPU inputs.
- Waits the per-opcode result latency, then captures the FPU result.
- Returns the result with tag and classification flags over a second valid/ready handshake. One operation in flight at a time.

---
 rtl/fpu_issue_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fpu_issue_ctrl.sv
// Single-issue sequencer in front of the FPU datapath: launches one
// operation, waits its opcode latency, then returns the captured result.
module fpu_issue_ctrl #(
    parameter int ADD_LAT = 3,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 26,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [1:0]       req_opcode,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      fpu_a,
    output logic [31:0]      fpu_b,
    output logic [1:0]       fpu_opcode,
    input  logic [31:0]      fpu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_nan,
    output logic             rsp_inf,
    output logic             rsp_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [5:0]       r_cnt;
    logic             r_req_ready;
    logic             r_rsp_valid;
    logic [31:0]      r_fpu_a;
    logic [31:0]      r_fpu_b;
    logic [1:0]       r_fpu_opcode;
    logic [TAG_W-1:0] r_tag;
    logic [TAG_W-1:0] r_rsp_tag;
    logic [31:0]      r_rsp_result;
    logic             r_nan;
    logic             r_inf;
    logic             r_zero;

    logic [5:0]       w_lat_m1;
    logic             w_exp_ones;
    logic             w_exp_zero;
    logic             w_man_nz;

    // Counter is loaded with latency-1 so capture lands exactly LAT edges later.
    always_comb begin
        w_lat_m1 = 6'(ADD_LAT - 1);
        unique case (req_opcode)
            2'b10:   w_lat_m1 = 6'(MUL_LAT - 1);
            2'b11:   w_lat_m1 = 6'(DIV_LAT - 1);
            default: w_lat_m1 = 6'(ADD_LAT - 1);
        endcase
    end

    assign w_exp_ones = &fpu_result[30:23];
    assign w_exp_zero = ~|fpu_result[30:23];
    assign w_man_nz   = |fpu_result[22:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_fpu_a      <= '0;
            r_fpu_b      <= '0;
            r_fpu_opcode <= '0;
            r_tag        <= '0;
            r_rsp_tag    <= '0;
            r_rsp_result <= '0;
            r_nan        <= 1'b0;
            r_inf        <= 1'b0;
            r_zero       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_fpu_a      <= req_a;
                        r_fpu_b      <= req_b;
                        r_fpu_opcode <= req_opcode;
                        r_tag        <= req_tag;
                        r_cnt        <= w_lat_m1;
                        r_req_ready  <= 1'b0;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == 6'd0) begin
                        r_rsp_result <= fpu_result;
                        r_rsp_tag    <= r_tag;
                        r_nan        <= w_exp_ones & w_man_nz;
                        r_inf        <= w_exp_ones & ~w_man_nz;
                        r_zero       <= w_exp_zero & ~w_man_nz;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 6'd1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign fpu_a      = r_fpu_a;
    assign fpu_b      = r_fpu_b;
    assign fpu_opcode = r_fpu_opcode;
    assign rsp_result = r_rsp_result;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_nan    = r_nan;
    assign rsp_inf    = r_inf;
    assign rsp_zero   = r_zero;

endmodule
